// File: rtl/regfile_dump.sv
// Sequential register-file reader: walks indices 0..NREGS-1 through a spare read port and
// streams each (index, value) pair on a valid/ready interface toward the trace/debug sink.
module regfile_dump #(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned NREGS  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              abort_i,
  output logic [4:0]        rf_addr_o,
  input  logic [DWIDTH-1:0] rf_data_i,
  output logic              dump_valid_o,
  input  logic              dump_ready_i,
  output logic [4:0]        dump_idx_o,
  output logic [DWIDTH-1:0] dump_data_o,
  output logic              busy_o,
  output logic              done_o
);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  localparam logic [4:0] LastIdx = 5'(NREGS - 1);

  state_e            state_q, state_d;
  logic [4:0]        rd_ptr_q, rd_ptr_d;
  logic [4:0]        out_idx_q, out_idx_d;
  logic [DWIDTH-1:0] out_data_q, out_data_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic              handshake;
  logic              last_entry;

  assign handshake  = valid_q & dump_ready_i;
  assign last_entry = (out_idx_q == LastIdx);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start_i && !abort_i) state_d = StSend;
      StSend: if (abort_i || (handshake && last_entry)) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    out_idx_d  = out_idx_q;
    out_data_d = out_data_q;
    valid_d    = valid_q;
    done_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i && !abort_i) begin
          out_data_d = rf_data_i;
          out_idx_d  = 5'd0;
          valid_d    = 1'b1;
          rd_ptr_d   = 5'd1;
        end
      end
      StSend: begin
        // Abort wins over a same-cycle handshake; that entry is dropped.
        if (abort_i) begin
          valid_d  = 1'b0;
          rd_ptr_d = 5'd0;
        end else if (handshake) begin
          if (last_entry) begin
            valid_d  = 1'b0;
            rd_ptr_d = 5'd0;
            done_d   = 1'b1;
          end else begin
            out_data_d = rf_data_i;
            out_idx_d  = rd_ptr_q;
            // Park on the last index so the read address never runs past the file.
            if (rd_ptr_q != LastIdx) rd_ptr_d = rd_ptr_q + 5'd1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q   <= '0;
      out_idx_q  <= '0;
      out_data_q <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      out_idx_q  <= out_idx_d;
      out_data_q <= out_data_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    rf_addr_o    = rd_ptr_q;
    dump_valid_o = valid_q;
    dump_idx_o   = out_idx_q;
    dump_data_o  = out_data_q;
    busy_o       = (state_q == StSend);
    done_o       = done_q;
  end

endmodule

// File: doc/regfile_dump.md
# regfile_dump

Sequential reader for the 32-entry integer register file, used for architectural-state dumps at end of test and on debug request. On a start pulse it walks register indices 0..NREGS-1 through one spare combinational read port of the register file. It emits each (index, value) pair on a valid/ready stream toward the trace/debug sink. It sits beside the decode stage, sharing the register file's second read port when the core is halted, and never writes the register file.

## Interface

Parameters:
- DWIDTH, 32, register data width
- NREGS, 32, number of registers dumped (2..32); index width fixed at 5

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- start_i  in  1  begin a dump; sampled only in IDLE
- abort_i  in  1  cancel an in-progress dump
- rf_addr_o  out  5  read address driven to the register file read port
- rf_data_i  in  DWIDTH  combinational read data for rf_addr_o, zero for index 0
- dump_valid_o  out  1  dump_idx_o/dump_data_o hold a valid entry
- dump_ready_i  in  1  sink accepts the entry this cycle
- dump_idx_o  out  5  register index of current entry
- dump_data_o  out  DWIDTH  register value of current entry
- busy_o  out  1  high while state is SEND
- done_o  out  1  one-cycle pulse after the last entry is accepted

## Operation

- Two states: IDLE and SEND. Registers: state, rd_ptr (5b), out_idx, out_data, valid, done.
- rf_addr_o = rd_ptr at all times (registered, glitch-free). rd_ptr is 0 in IDLE.
- IDLE, start_i=1 and abort_i=0:
  - capture rf_data_i (index 0) into out_data, out_idx=0
  - valid=1, rd_ptr=1, go to SEND
- IDLE, other inputs: hold; start_i with abort_i=1 is ignored.
- SEND, handshake (valid & dump_ready_i), out_idx < NREGS-1:
  - load out_data=rf_data_i, out_idx=rd_ptr, rd_ptr++
  - valid stays 1, giving back-to-back throughput of one entry per cycle
- SEND, handshake, out_idx == NREGS-1: valid=0, rd_ptr=0, done=1 for the next cycle, go to IDLE.
- SEND, no handshake: all output registers hold. Data and index stay stable while valid is high and ready is low.
- abort_i=1 in SEND: go to IDLE, valid=0, rd_ptr=0, no done pulse. Abort overrides a same-cycle handshake; that entry counts as not delivered.
- start_i in SEND is ignored. A new dump can start in the cycle done_o is high, since the state is already IDLE.
- Values are read at load time, not at start. Writes landing during a dump are visible for indices not yet loaded. The owner halts writeback for a consistent snapshot.
- rd_ptr never exceeds NREGS-1 as an address driven while busy. No wrap beyond index NREGS-1.

## Timing

- Reset (rst low, asynchronous) forces:
  - state=IDLE, rd_ptr=0, rf_addr_o=0
  - dump_valid_o=0, dump_idx_o=0, dump_data_o=0
  - busy_o=0, done_o=0
- Reset takes effect immediately, including mid-dump. Release is synchronous to the next clk edge.
- start_i high at edge of cycle 0: dump_valid_o high in cycle 1 with index 0.
- Ready held high: entry k is presented in cycle 1+k. The last entry (NREGS-1) is accepted at the end of cycle NREGS. done_o is high in cycle NREGS+1.
- Minimum dump duration: NREGS+1 cycles from start to done_o.
- busy_o = (state==SEND), registered.

## Test plan

- Preload x1..x31 with 0x100+i and x0 with zero, hold ready=1, pulse start. Required:
  - 32 consecutive entries in cycles 1..32, idx 0..31
  - data 0 for idx 0 and 0x100+idx otherwise
  - done_o high in cycle 33 only
- Backpressure: ready toggles 1,0,0,1 repeating. Each entry is held stable across ready-low cycles. No index is skipped or duplicated. done_o fires once after idx 31.
- Abort with ready=1: assert abort_i in the cycle idx 5 is presented. dump_valid_o is 0 next cycle, no done_o pulse, rf_addr_o returns to 0. A following start restarts from idx 0.
- Reset mid-dump: drive rst low asynchronously between edges during idx 10. All outputs go to reset values immediately. After release there is no activity until a new start.
- Concurrent write: during a dump, write x20=0xDEADBEEF at cycle 5. The dump reports 0xDEADBEEF for idx 20. start_i pulses while busy are ignored, and exactly one done_o pulse occurs.
- Parameterisation: with NREGS=4, the dump emits idx 0..3 then done_o in cycle 5. rf_addr_o never exceeds 3 while busy.
